// File: rtl/ysyx_22050598_idu_pkg.sv
// Shared decode constants and decoded-record layout for the IDU stage and EXU.
// Optional RV64 W-opcode decoding is enabled by YSYX_22050598_IDU_RV64W_EN.
package ysyx_22050598_idu_pkg;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    localparam int TYPE_W     = 6;
    localparam int TYPE_BIT_I = 5;
    localparam int TYPE_BIT_S = 4;
    localparam int TYPE_BIT_B = 3;
    localparam int TYPE_BIT_U = 2;
    localparam int TYPE_BIT_J = 1;
    localparam int TYPE_BIT_R = 0;

    localparam logic [TYPE_W-1:0] TYPE_NONE = 6'b000000;
    localparam logic [TYPE_W-1:0] TYPE_I    = 6'b100000;
    localparam logic [TYPE_W-1:0] TYPE_S    = 6'b010000;
    localparam logic [TYPE_W-1:0] TYPE_B    = 6'b001000;
    localparam logic [TYPE_W-1:0] TYPE_U    = 6'b000100;
    localparam logic [TYPE_W-1:0] TYPE_J    = 6'b000010;
    localparam logic [TYPE_W-1:0] TYPE_R    = 6'b000001;

    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    localparam int REG_IDX_W = 5;
    localparam int FUNCT3_W  = 3;
    localparam int FUNCT7_W  = 7;

    // XLEN-independent part of a decoded record; pc and immediates are
    // appended by the user at their own widths.
    typedef struct packed {
        logic [31:0]       inst;
        logic [TYPE_W-1:0] typ;
        logic              illegal;
        logic              ebreak;
    } idu_ctrl_t;

endpackage

// File: rtl/ysyx_22050598_idu_dec.sv
// Combinational RISC-V decoder: format one-hot, signed/unsigned immediates,
// illegal and ebreak flags. W opcodes decode only with YSYX_22050598_IDU_RV64W_EN and XLEN=64.
module ysyx_22050598_idu_dec
    import ysyx_22050598_idu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]       inst_i,
    output logic [TYPE_W-1:0] type_o,
    output logic [XLEN-1:0]   imm_o,
    output logic [XLEN-1:0]   immu_o,
    output logic              illegal_o,
    output logic              ebreak_o
);

`ifdef YSYX_22050598_IDU_RV64W_EN
    localparam bit W_EN = (XLEN == 64);
`else
    localparam bit W_EN = 1'b0;
`endif

    logic [31:0] imm_s32;
    logic [31:0] imm_u32;

    always_comb begin
        type_o    = TYPE_NONE;
        illegal_o = 1'b0;
        case (inst_i[6:0])
            OPC_LUI, OPC_AUIPC:                         type_o = TYPE_U;
            OPC_JAL:                                    type_o = TYPE_J;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM: type_o = TYPE_I;
            OPC_BRANCH:                                 type_o = TYPE_B;
            OPC_STORE:                                  type_o = TYPE_S;
            OPC_OP:                                     type_o = TYPE_R;
            OPC_OP_IMM_32: begin
                if (W_EN) type_o    = TYPE_I;
                else      illegal_o = 1'b1;
            end
            OPC_OP_32: begin
                if (W_EN) type_o    = TYPE_R;
                else      illegal_o = 1'b1;
            end
            default:                                    illegal_o = 1'b1;
        endcase
    end

    // Immediates are assembled at 32 bits, then widened to XLEN by casting.
    always_comb begin
        imm_s32 = 32'd0;
        imm_u32 = 32'd0;
        case (type_o)
            TYPE_I: begin
                imm_u32 = {20'd0, inst_i[31:20]};
                imm_s32 = {{20{inst_i[31]}}, inst_i[31:20]};
            end
            TYPE_S: begin
                imm_u32 = {20'd0, inst_i[31:25], inst_i[11:7]};
                imm_s32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            end
            TYPE_B: begin
                imm_u32 = {19'd0, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
                imm_s32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
            end
            TYPE_U: begin
                imm_u32 = {inst_i[31:12], 12'd0};
                imm_s32 = {inst_i[31:12], 12'd0};
            end
            TYPE_J: begin
                imm_u32 = {11'd0, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
                imm_s32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
            end
            default: begin
                imm_s32 = 32'd0;
                imm_u32 = 32'd0;
            end
        endcase
    end

    assign imm_o    = XLEN'($signed(imm_s32));
    assign immu_o   = XLEN'(imm_u32);
    assign ebreak_o = (inst_i == EBREAK_INST);

endmodule

// File: rtl/ysyx_22050598_idu_stage.sv
// IDU pipeline stage: decodes {pc, inst} and holds results in a 2-entry skid
// buffer (main + skid) with flush. W opcodes gated by YSYX_22050598_IDU_RV64W_EN.
module ysyx_22050598_idu_stage
    import ysyx_22050598_idu_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int PC_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PC_W-1:0]      in_pc,
    input  logic [31:0]          in_inst,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PC_W-1:0]      out_pc,
    output logic [31:0]          out_inst,
    output logic [REG_IDX_W-1:0] out_rs1,
    output logic [REG_IDX_W-1:0] out_rs2,
    output logic [REG_IDX_W-1:0] out_rd,
    output logic [FUNCT3_W-1:0]  out_funct3,
    output logic [FUNCT7_W-1:0]  out_funct7,
    output logic [TYPE_W-1:0]    out_type,
    output logic [XLEN-1:0]      out_imm,
    output logic [XLEN-1:0]      out_immu,
    output logic                 out_illegal,
    output logic                 out_ebreak
);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        idu_ctrl_t       ctrl;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] immu;
    } rec_t;

    logic [TYPE_W-1:0] dec_type;
    logic [XLEN-1:0]   dec_imm;
    logic [XLEN-1:0]   dec_immu;
    logic              dec_illegal;
    logic              dec_ebreak;
    rec_t              dec_rec;

    rec_t main_q, main_d;
    rec_t skid_q, skid_d;
    logic main_valid_q, main_valid_d;
    logic skid_valid_q, skid_valid_d;

    logic accept;
    logic consume;

    ysyx_22050598_idu_dec #(
        .XLEN(XLEN)
    ) u_dec (
        .inst_i   (in_inst),
        .type_o   (dec_type),
        .imm_o    (dec_imm),
        .immu_o   (dec_immu),
        .illegal_o(dec_illegal),
        .ebreak_o (dec_ebreak)
    );

    always_comb begin
        dec_rec              = '0;
        dec_rec.pc           = in_pc;
        dec_rec.ctrl.inst    = in_inst;
        dec_rec.ctrl.typ     = dec_type;
        dec_rec.ctrl.illegal = dec_illegal;
        dec_rec.ctrl.ebreak  = dec_ebreak;
        dec_rec.imm          = dec_imm;
        dec_rec.immu         = dec_immu;
    end

    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid & in_ready & ~flush;
    assign consume  = main_valid_q & out_ready;

    // Skid can only be occupied while main is; an accept never coincides
    // with a full skid because in_ready is already low then.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (consume) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d = dec_rec;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (main_valid_q) begin
                skid_d       = dec_rec;
                skid_valid_d = 1'b1;
            end else begin
                main_d       = dec_rec;
                main_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid   = main_valid_q;
    assign out_pc      = main_q.pc;
    assign out_inst    = main_q.ctrl.inst;
    assign out_rs1     = main_q.ctrl.inst[19:15];
    assign out_rs2     = main_q.ctrl.inst[24:20];
    assign out_rd      = main_q.ctrl.inst[11:7];
    assign out_funct3  = main_q.ctrl.inst[14:12];
    assign out_funct7  = main_q.ctrl.inst[31:25];
    assign out_type    = main_q.ctrl.typ;
    assign out_imm     = main_q.imm;
    assign out_immu    = main_q.immu;
    assign out_illegal = main_q.ctrl.illegal;
    assign out_ebreak  = main_q.ctrl.ebreak;

endmodule

// File: tb/tb_ysyx_22050598_idu_stage.sv
// Scoreboard bench for the IDU stage: directed decode/handshake cases plus
// random traffic checked against a field-level decode model.
module tb_ysyx_22050598_idu_stage;

    localparam int XLEN = 64;
    localparam int PC_W = 64;

`ifdef YSYX_22050598_IDU_RV64W_EN
    localparam bit W_EN = 1'b1;
`else
    localparam bit W_EN = 1'b0;
`endif

    logic            clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [PC_W-1:0] in_pc, out_pc;
    logic [31:0]     in_inst, out_inst;
    logic [4:0]      out_rs1, out_rs2, out_rd;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [5:0]      out_type;
    logic [XLEN-1:0] out_imm, out_immu;
    logic            out_illegal, out_ebreak;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [5:0]  typ;
        logic [63:0] imm, immu;
        logic        ill, ebr;
    } rec_t;

    rec_t exp_q[$];
    int   assertions = 0;
    int   failures   = 0;
    int   retired    = 0;

    ysyx_22050598_idu_stage #(.XLEN(XLEN), .PC_W(PC_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_funct3(out_funct3), .out_funct7(out_funct7), .out_type(out_type),
        .out_imm(out_imm), .out_immu(out_immu), .out_illegal(out_illegal), .out_ebreak(out_ebreak)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference decode: pick the format, gather the immediate field and its
    // width, then sign-extend arithmetically from the top bit of that field.
    function automatic rec_t model(input logic [63:0] pc, input logic [31:0] inst);
        rec_t        r;
        logic [63:0] field;
        int          w;
        byte         fmt;
        r      = '0;
        r.pc   = pc;
        r.inst = inst;
        r.rs1  = inst[19:15];
        r.rs2  = inst[24:20];
        r.rd   = inst[11:7];
        r.f3   = inst[14:12];
        r.f7   = inst[31:25];
        r.ebr  = (inst == 32'h0010_0073);
        case (inst[6:0])
            7'h37, 7'h17:               fmt = "U";
            7'h6F:                      fmt = "J";
            7'h67, 7'h03, 7'h13, 7'h73: fmt = "I";
            7'h63:                      fmt = "B";
            7'h23:                      fmt = "S";
            7'h33:                      fmt = "R";
            7'h1B:                      fmt = W_EN ? "I" : "X";
            7'h3B:                      fmt = W_EN ? "R" : "X";
            default:                    fmt = "X";
        endcase
        field = 64'd0;
        w     = 0;
        case (fmt)
            "I": begin r.typ = 6'b100000; field = 64'(inst[31:20]); w = 12; end
            "S": begin r.typ = 6'b010000; field = 64'({inst[31:25], inst[11:7]}); w = 12; end
            "B": begin r.typ = 6'b001000; field = 64'({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}); w = 13; end
            "U": begin r.typ = 6'b000100; field = 64'({inst[31:12], 12'd0}); w = 32; end
            "J": begin r.typ = 6'b000010; field = 64'({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}); w = 21; end
            "R": r.typ = 6'b000001;
            default: begin r.typ = 6'b000000; r.ill = 1'b1; end
        endcase
        r.immu = field;
        r.imm  = (w > 0 && field[w-1]) ? (field | (~64'd0 << w)) : field;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Stimulus side of the scoreboard: every accepted instruction is modelled.
    always @(negedge clk) begin
        if (!rst) begin
            if (flush) begin
                exp_q.delete();
            end else if (in_valid && in_ready) begin
                exp_q.push_back(model(in_pc, in_inst));
                $display("issue  pc=%h inst=%h", in_pc, in_inst);
            end
        end
    end

    // Monitor: whatever the DUT presents must be the oldest outstanding entry.
    always @(negedge clk) begin
        rec_t act;
        if (!rst && out_valid && !flush) begin
            act = '{pc: out_pc, inst: out_inst, rs1: out_rs1, rs2: out_rs2, rd: out_rd,
                    f3: out_funct3, f7: out_funct7, typ: out_type, imm: out_imm,
                    immu: out_immu, ill: out_illegal, ebr: out_ebreak};
            assertions++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output actual=%h required=none", act);
            end else begin
                if (act !== exp_q[0]) begin
                    failures++;
                    $display("FAIL output_record actual=%h required=%h", act, exp_q[0]);
                end
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    retired++;
                    $display("retire pc=%h inst=%h type=%b imm=%h", out_pc, out_inst, out_type, out_imm);
                end
            end
        end
    end

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic issue(input logic [31:0] inst, input logic [63:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        chk("accept_wait", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13,
                                  7'h73, 7'h63, 7'h23, 7'h33, 7'h1B, 7'h3B};
        logic [31:0] r;
        int          idx;
        r   = $urandom;
        idx = $urandom_range(0, 13);
        if (idx < 12) r[6:0] = ops[idx];
        if ($urandom_range(0, 19) == 0) r = 32'h0010_0073;
        return r;
    endfunction

    logic [31:0] d_inst [7] = '{32'hFFF0_0093, 32'h8000_02B7, 32'hFFDF_F0EF, 32'h0000_0463,
                                32'h0000_007F, 32'h0000_001B, 32'h0010_0073};
    logic [5:0]  d_type [7] = '{6'b100000, 6'b000100, 6'b000010, 6'b001000,
                                6'b000000, (W_EN ? 6'b100000 : 6'b000000), 6'b100000};
    logic [63:0] d_imm  [7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000,
                                64'hFFFF_FFFF_FFFF_FFFC, 64'd8, 64'd0, 64'd0, 64'd1};
    logic [63:0] d_immu [7] = '{64'hFFF, 64'h8000_0000, 64'h1F_FFFC, 64'd8, 64'd0, 64'd0, 64'd1};
    logic        d_ill  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, !W_EN, 1'b0};
    logic        d_ebr  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_inst = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready",  64'(in_ready),  64'd1);
        chk("reset_out_pc",    out_pc,         64'd0);
        chk("reset_out_inst",  64'(out_inst),  64'd0);
        chk("reset_out_imm",   out_imm,        64'd0);
        chk("reset_out_type",  64'(out_type),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed decodes, one-cycle latency with an empty buffer
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            issue(d_inst[i], 64'h8000_0000 + 64'(i * 4));
            chk("dir_out_valid", 64'(out_valid),    64'd1);
            chk("dir_type",      64'(out_type),     64'(d_type[i]));
            chk("dir_imm",       out_imm,           d_imm[i]);
            chk("dir_immu",      out_immu,          d_immu[i]);
            chk("dir_illegal",   64'(out_illegal),  64'(d_ill[i]));
            chk("dir_ebreak",    64'(out_ebreak),   64'(d_ebr[i]));
            if (i == 0) begin
                chk("addi_rd",  64'(out_rd),  64'd1);
                chk("addi_rs1", 64'(out_rs1), 64'd0);
            end
        end
        @(posedge clk);
        #1;

        // Stall with three back-to-back offers
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h0011_0113; in_pc = 64'h100;
        @(posedge clk); #1;
        in_inst = 32'h0021_8193; in_pc = 64'h104;
        @(posedge clk); #1;
        chk("stall_in_ready_low", 64'(in_ready), 64'd0);
        chk("stall_head",         64'(out_inst), 64'h0011_0113);
        in_inst = 32'h0032_0213; in_pc = 64'h108;
        @(posedge clk); #1;
        chk("stall_in_ready_held", 64'(in_ready), 64'd0);
        chk("stall_head_stable",   64'(out_inst), 64'h0011_0113);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("drain_second", 64'(out_inst),  64'h0021_8193);
        chk("drain_valid2", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("drain_third",  64'(out_inst),  64'h0032_0213);
        chk("drain_valid3", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        chk("drain_empty_valid", 64'(out_valid), 64'd0);

        // Flush with two buffered entries
        out_ready = 1'b0;
        issue(32'h0000_0513, 64'h200);
        issue(32'h0000_0593, 64'h204);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        flush = 1'b1; in_valid = 1'b1; in_inst = 32'h0000_0613; in_pc = 64'h208;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready",  64'(in_ready),  64'd1);

        // Flush beats a same-cycle accept
        issue(32'h0000_0693, 64'h300);
        flush = 1'b1; in_valid = 1'b1; in_inst = 32'h0000_0713; in_pc = 64'h304;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("flush_acc_out_valid", 64'(out_valid), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("flush_acc_never_out", 64'(out_valid), 64'd0);

        // Random traffic
        for (int cyc = 0; cyc < 800; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_inst   = rand_inst();
            in_pc     = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("random_drained", 64'(exp_q.size()), 64'd0);
        chk("random_out_idle", 64'(out_valid), 64'd0);

        // Asynchronous reset with entries buffered
        out_ready = 1'b0;
        issue(32'h0000_0793, 64'h400);
        issue(32'h0000_0813, 64'h404);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_in_ready",  64'(in_ready),  64'd1);
        chk("async_rst_out_inst",  64'(out_inst),  64'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_idle", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_22050598_idu_stage.md
Name: ysyx_22050598_idu_stage

Overview:
- Pipelined, parametrised instruction-decode stage sitting between IFU and EXU.
- Accepts {pc, inst} over a valid/ready handshake and decodes it: register indices, funct fields, one-hot format type, signed and unsigned immediates at XLEN, illegal-opcode flag and ebreak flag.
- Registers the decoded result behind a 2-entry skid buffer so that in_ready is a registered signal.
- Supports a synchronous flush for branch redirect.

Parameters:
- XLEN, 64, datapath width; legal values 32 and 64.
- PC_W, 64, pc width carried through the stage.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  synchronous; drops all buffered entries
- in_valid  in  1  upstream holds an instruction
- in_ready  out  1  stage can accept
- in_pc  in  PC_W  pc of in_inst
- in_inst  in  32  raw instruction
- out_valid  out  1  decoded entry available
- out_ready  in  1  downstream accepts
- out_pc  out  PC_W  pc passthrough
- out_inst  out  32  instruction passthrough
- out_rs1 / out_rs2 / out_rd  out  5 each  inst[19:15] / inst[24:20] / inst[11:7]
- out_funct3  out  3  inst[14:12]
- out_funct7  out  7  inst[31:25]
- out_type  out  6  one-hot format: [5]=I, [4]=S, [3]=B, [2]=U, [1]=J, [0]=R; 0 = none
- out_imm  out  XLEN  sign-extended immediate for out_type
- out_immu  out  XLEN  zero-extended immediate for out_type
- out_illegal  out  1  opcode not recognised
- out_ebreak  out  1  inst == 32'h0010_0073

Behaviour:
- Reset (async, rst=1): both buffer entries are invalid. out_valid=0, in_ready=1, all out_* data fields are 0.
- Opcode map:
  - U: LUI 0110111, AUIPC 0010111
  - J: JAL 1101111
  - I: JALR 1100111, LOAD 0000011, OP-IMM 0010011, SYSTEM 1110011
  - B: 1100011
  - S: 0100011
  - R: OP 0110011
  - Anything else: type=0 and illegal=1.
- Signed immediates, each sign-extended from inst[31] to XLEN:
  - I = inst[31:20]
  - S = {inst[31:25], inst[11:7]}
  - B = {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U = {inst[31:12], 12'b0}
  - J = {inst[31], inst[19:12], inst[20], inst[30:21], 0}
- Unsigned immediates: the same bit fields, zero-extended to XLEN.
- R-type and type=0: imm and immu are 0.
- Decode is combinational on the input side; the result is captured on the accept edge (in_valid & in_ready).
- Latency: 1 cycle from accept to out_valid when the buffer is empty.
- Main entry drives out_*. The skid entry captures an accept made while the main entry is valid and not being consumed.
- in_ready = !skid_valid (registered).
- Consume (out_valid & out_ready) with skid valid: skid moves to main in that cycle. Any simultaneous accept goes to skid only if skid is freed this cycle; otherwise in_ready was already 0.
- Accept and consume together with skid empty: the new entry replaces main and out_valid stays 1.
- Ordering is strictly FIFO; no entry is dropped or duplicated.
- out_* fields are stable while out_valid & !out_ready.
- flush: next cycle out_valid=0 and in_ready=1.
  - Flush has priority over a same-cycle accept; that instruction is discarded.
  - Data fields may retain stale values.
- Reset asserted mid-operation clears both entries immediately (async).

Optional Feature:
- Macro: YSYX_22050598_IDU_RV64W_EN.
- Defined and XLEN=64:
  - OP-IMM-32 0011011 decodes as I-type.
  - OP-32 0111011 decodes as R-type.
  - Both give illegal=0.
- Undefined, or XLEN=32: both opcodes give type=0 and illegal=1.

Decomposition:
- Shared package/defines header holds:
  - opcode constants (10 base + 2 W)
  - type one-hot constants and bit positions
  - the ebreak encoding
  - the decoded-record field layout, so EXU reuses them
- One natural sub-module: ysyx_22050598_idu_dec, the purely combinational inst → {type, imm, immu, illegal, ebreak} decoder, parametrised by XLEN and instantiated once on the input side.
- The stage module owns the handshake and the skid buffer.

Test Plan:
- addi x1,x0,-1 (0xFFF00093), XLEN=64, out_ready=1 → next cycle: out_valid=1, type=6'b100000, imm=0xFFFF_FFFF_FFFF_FFFF, immu=0xFFF, rd=1, rs1=0.
- lui x5,0x80000 (0x800002B7) → type=6'b000100, imm=0xFFFF_FFFF_8000_0000, immu=0x8000_0000; with XLEN=32: imm=0x8000_0000.
- jal x1,-4 (0xFFDFF0EF) → type=6'b000010, imm=0xFFFF_FFFF_FFFF_FFFC, immu=0x1F_FFFC; beq x0,x0,+8 (0x00000463) → type=6'b001000, imm=8.
- out_ready=0 with 3 back-to-back in_valid → 2 accepted, in_ready=0 from the cycle after the 2nd accept. Then out_ready=1 → the 3 emerge in order, one per cycle.
- Stall with 2 entries buffered, pulse flush → next cycle out_valid=0, in_ready=1. An accept offered during the flush cycle never appears at the output.
- 0x0000007F → type=0, illegal=1, imm=0. 0x0000001B → illegal=1 without the macro; type=6'b100000, illegal=0 with the macro. 0x00100073 → type I, ebreak=1.
